// File: rtl/crotchet_sequencer.sv
// crotchet_sequencer
//   Master timeline for the demo. Counts video frames (frame_tick pulses from the
//   VGA timing generator) into crotchets and drives the 7-bit crotchet index used
//   by the display renderer and the audio path. Offers play/pause/loop control
//   and a seek handshake for the debug/UI inputs.
//
// Parameters
//   FRAMES_PER_CROTCHET  frames per crotchet, 2..64
//   NUM_CROTCHETS        crotchets in the sequence, 1..128
//   LOOP_START           index reloaded on wrap when loop_en=1 (< NUM_CROTCHETS)
//
// Ports
//   clk            in   clock
//   rst_n          in   synchronous active-low reset
//   frame_tick     in   one-cycle pulse per video frame
//   start          in   begin/resume playback
//   pause          in   halt playback, hold position
//   loop_en        in   1: wrap to LOOP_START at the end, 0: stop in DONE
//   seek_valid     in   seek request
//   seek_crotchet  in   seek target index (clamped to NUM_CROTCHETS-1)
//   seek_ready     out  seek accepted when seek_valid && seek_ready
//   crotchet       out  current crotchet index
//   beat_pulse     out  one-cycle pulse when playback advances the crotchet
//   phrase_pulse   out  one-cycle pulse when that advance lands on index[2:0]==0
//   playing        out  sequencer is in PLAY
//   done           out  sequencer is in DONE
module crotchet_sequencer #(
  parameter int FRAMES_PER_CROTCHET = 52,
  parameter int NUM_CROTCHETS       = 104,
  parameter int LOOP_START          = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       loop_en,
  input  logic       seek_valid,
  input  logic [6:0] seek_crotchet,
  output logic       seek_ready,
  output logic [6:0] crotchet,
  output logic       beat_pulse,
  output logic       phrase_pulse,
  output logic       playing,
  output logic       done
);

  localparam int CW = $clog2(FRAMES_PER_CROTCHET);

  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAMES_PER_CROTCHET - 1);
  localparam logic [6:0]    LAST_IDX   = 7'(NUM_CROTCHETS - 1);
  localparam logic [6:0]    LOOP_IDX   = 7'(LOOP_START);
  localparam logic          LOOP_PHRASE = ((LOOP_START % 8) == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_PAUSED,
    S_DONE
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] frame_cnt, frame_cnt_next;
  logic [6:0]    crotchet_next;
  logic          beat_next, phrase_next;
  logic          seek_accept;
  logic [6:0]    seek_target;

  // A seek is never accepted in a frame_tick cycle, so a seek can never collide
  // with a playback advance.
  assign seek_ready  = !frame_tick;
  assign seek_accept = seek_valid && !frame_tick;

  // Out-of-range targets clamp to the last crotchet; NUM_CROTCHETS may be 128,
  // so the comparison is done one bit wider.
  assign seek_target = ({1'b0, seek_crotchet} >= 8'(NUM_CROTCHETS)) ? LAST_IDX
                                                                    : seek_crotchet;

  assign playing = (state == S_PLAY);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      frame_cnt    <= '0;
      crotchet     <= '0;
      beat_pulse   <= 1'b0;
      phrase_pulse <= 1'b0;
    end else begin
      state        <= state_next;
      frame_cnt    <= frame_cnt_next;
      crotchet     <= crotchet_next;
      beat_pulse   <= beat_next;
      phrase_pulse <= phrase_next;
    end
  end

  // Next-state logic. A pause arriving together with a frame_tick in PLAY
  // holds position: the tick is not counted.
  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    crotchet_next  = crotchet;
    beat_next      = 1'b0;
    phrase_next    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next     = S_PLAY;
          frame_cnt_next = '0;
        end
      end

      S_PLAY: begin
        if (pause) begin
          state_next = S_PAUSED;
        end else if (frame_tick) begin
          if (frame_cnt != FRAME_LAST) begin
            frame_cnt_next = frame_cnt + 1'b1;
          end else begin
            frame_cnt_next = '0;
            if (crotchet != LAST_IDX) begin
              crotchet_next = crotchet + 7'd1;
              beat_next     = 1'b1;
              phrase_next   = (crotchet[2:0] == 3'd7);
            end else if (loop_en) begin
              crotchet_next = LOOP_IDX;
              beat_next     = 1'b1;
              phrase_next   = LOOP_PHRASE;
            end else begin
              // End of sequence without looping: park on the last crotchet.
              state_next = S_DONE;
            end
          end
        end
      end

      S_PAUSED: begin
        if (start && !pause) begin
          state_next = S_PLAY;
        end
      end

      S_DONE: begin
        if (start) begin
          state_next     = S_PLAY;
          crotchet_next  = LOOP_IDX;
          frame_cnt_next = '0;
        end else if (seek_accept) begin
          // Seeking out of DONE leaves the sequencer paused at the new spot.
          state_next = S_PAUSED;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Seek position overrides whatever start/pause did to the position.
    if (seek_accept) begin
      crotchet_next  = seek_target;
      frame_cnt_next = '0;
    end
  end

endmodule

// File: tb/tb_crotchet_sequencer.sv
// tb_crotchet_sequencer
//   Drives crotchet_sequencer with directed scenarios followed by randomized
//   traffic. A reference model tracks playback as an absolute frame position
//   (crotchet * FRAMES_PER_CROTCHET + frames into the crotchet) and pushes the
//   expected outputs for every clock into a queue; a separate monitor pops and
//   compares them one time unit after each rising edge.
module tb_crotchet_sequencer;

  localparam int FPC = 52;
  localparam int NUM = 104;
  localparam int LS  = 0;

  localparam int M_IDLE   = 0;
  localparam int M_PLAY   = 1;
  localparam int M_PAUSED = 2;
  localparam int M_DONE   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       start;
  logic       pause;
  logic       loop_en;
  logic       seek_valid;
  logic [6:0] seek_crotchet;
  logic       seek_ready;
  logic [6:0] crotchet;
  logic       beat_pulse;
  logic       phrase_pulse;
  logic       playing;
  logic       done;

  typedef struct packed {
    logic [6:0] crotchet;
    logic       beat;
    logic       phrase;
    logic       playing;
    logic       done;
    logic       seek_ready;
  } obs_t;

  obs_t exp_q[$];

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int m_mode = M_IDLE;
  int m_pos  = 0;
  int cur_loop = 0;

  always #5 clk = ~clk;

  crotchet_sequencer #(
    .FRAMES_PER_CROTCHET(FPC),
    .NUM_CROTCHETS(NUM),
    .LOOP_START(LS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_tick(frame_tick),
    .start(start),
    .pause(pause),
    .loop_en(loop_en),
    .seek_valid(seek_valid),
    .seek_crotchet(seek_crotchet),
    .seek_ready(seek_ready),
    .crotchet(crotchet),
    .beat_pulse(beat_pulse),
    .phrase_pulse(phrase_pulse),
    .playing(playing),
    .done(done)
  );

  // Drive one cycle of inputs, advance the model, queue the expectation.
  task automatic applyStimulus(input logic r, input logic s, input logic p,
                               input logic l, input logic t, input logic sv,
                               input logic [6:0] sc);
    int   cur;
    int   next_pos;
    int   target;
    bit   seek_acc;
    bit   m_beat;
    bit   m_phrase;
    obs_t e;
    rst_n         = r;
    start         = s;
    pause         = p;
    loop_en       = l;
    frame_tick    = t;
    seek_valid    = sv;
    seek_crotchet = sc;
    seek_acc = sv && !t;
    m_beat   = 1'b0;
    m_phrase = 1'b0;
    if (!r) begin
      m_mode = M_IDLE;
      m_pos  = 0;
    end else begin
      cur = m_pos / FPC;
      case (m_mode)
        M_IDLE: begin
          if (s) begin
            m_mode = M_PLAY;
            m_pos  = cur * FPC;
          end
        end
        M_PLAY: begin
          if (p) begin
            m_mode = M_PAUSED;
          end else if (t) begin
            next_pos = m_pos + 1;
            if (next_pos % FPC != 0) begin
              m_pos = next_pos;
            end else if (next_pos / FPC < NUM) begin
              m_pos    = next_pos;
              m_beat   = 1'b1;
              m_phrase = ((next_pos / FPC) % 8 == 0);
            end else if (l) begin
              m_pos    = LS * FPC;
              m_beat   = 1'b1;
              m_phrase = (LS % 8 == 0);
            end else begin
              m_mode = M_DONE;
              m_pos  = cur * FPC;
            end
          end
        end
        M_PAUSED: begin
          if (s && !p) m_mode = M_PLAY;
        end
        default: begin
          if (s) begin
            m_mode = M_PLAY;
            m_pos  = LS * FPC;
          end else if (seek_acc) begin
            m_mode = M_PAUSED;
          end
        end
      endcase
      if (seek_acc) begin
        target = int'(sc);
        if (target >= NUM) target = NUM - 1;
        m_pos = target * FPC;
      end
    end
    e.crotchet   = 7'(m_pos / FPC);
    e.beat       = m_beat;
    e.phrase     = m_phrase;
    e.playing    = (m_mode == M_PLAY);
    e.done       = (m_mode == M_DONE);
    e.seek_ready = !t;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic checkOutput(input obs_t e);
    obs_t a;
    a = {crotchet, beat_pulse, phrase_pulse, playing, done, seek_ready};
    tests_run++;
    if (a !== e) begin
      tests_failed++;
      $display("[TB] FAIL outputs @%0t: got crotchet=%0d beat=%b phrase=%b playing=%b done=%b seek_ready=%b, expected crotchet=%0d beat=%b phrase=%b playing=%b done=%b seek_ready=%b",
               $time, a.crotchet, a.beat, a.phrase, a.playing, a.done, a.seek_ready,
               e.crotchet, e.beat, e.phrase, e.playing, e.done, e.seek_ready);
    end
  endtask

  // Helpers for the directed scenarios
  task automatic runTicks(input int n, input logic t);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'(cur_loop), t, 1'b0, 7'd0);
  endtask

  task automatic doStart();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'(cur_loop), 1'b0, 1'b0, 7'd0);
  endtask

  task automatic doSeek(input logic [6:0] target);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'(cur_loop), 1'b0, 1'b1, target);
  endtask

  // Monitor: compare the registered outputs after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    logic       r_s, r_p, r_t, r_sv, r_r;
    logic [6:0] r_sc;

    // Reset
    cur_loop = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    runTicks(2, 1'b0);

    // First crotchet advance after 52 ticks
    doStart();
    runTicks(FPC, 1'b1);
    runTicks(2, 1'b0);

    // One full phrase from crotchet 0
    doSeek(7'd0);
    runTicks(8 * FPC, 1'b1);

    // End of sequence without loop, then restart from DONE
    cur_loop = 0;
    doSeek(7'd103);
    runTicks(FPC, 1'b1);
    runTicks(3, 1'b0);
    doStart();
    runTicks(2, 1'b0);

    // End of sequence with loop
    cur_loop = 1;
    doSeek(7'd103);
    runTicks(FPC, 1'b1);
    runTicks(2, 1'b0);

    // Pause mid-crotchet, ticks while paused, resume
    doSeek(7'd0);
    runTicks(30, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0);
    runTicks(100, 1'b1);
    doStart();
    runTicks(22, 1'b1);
    runTicks(2, 1'b0);

    // Seek blocked by frame_tick, then clamped seek
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'd50);
    doSeek(7'd120);
    runTicks(2, 1'b0);

    // Mid-playback reset
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0);
    runTicks(2, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 199) == 0) cur_loop = 1 - cur_loop;
      r_r  = ($urandom_range(0, 2999) != 0);
      r_s  = ($urandom_range(0, 99) < 3);
      r_p  = ($urandom_range(0, 99) < 2);
      r_t  = ($urandom_range(0, 1) == 1);
      r_sv = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 1) == 1) r_sc = 7'($urandom_range(96, 127));
      else                           r_sc = 7'($urandom_range(0, 127));
      applyStimulus(r_r, r_s, r_p, 1'(cur_loop), r_t, r_sv, r_sc);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
